fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_if.sv | 42 ++++
 rtl/fifo_rr_pick2.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Contents: default parameter values and the arbiter state type.
package fifo_arb_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_CNT_W     = 9;
  localparam int DEF_DEPTH     = 512;
  localparam int DEF_BURST_LEN = 16;
  localparam int DEF_RST_WAIT  = 80;

  // Only three of the four codes are used. The spare code 2'b11 is
  // steered back to IDLE by the next-state logic, so a corrupted state
  // register recovers without granting anyone.
  typedef enum logic [1:0] {
    WAIT  = 2'b00,
    IDLE  = 2'b01,
    BURST = 2'b10
  } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bus between the two write requesters, the arbiter and the FIFO write port.
// Handshake: a requester raises reqN to ask for a burst and keeps it high
// for as long as it wants the port. While gntN is high it presents dataN
// with validN. ackN is the fire strobe (grant & valid & FIFO not full):
// the word on dataN is written at the coming edge and the requester moves
// to its next word. Dropping reqN during a grant ends the burst early.
// Modports: master = requesters + FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic              req0;
  logic              valid0;
  logic [DATA_W-1:0] data0;
  logic              gnt0;
  logic              ack0;

  logic              req1;
  logic              valid1;
  logic [DATA_W-1:0] data1;
  logic              gnt1;
  logic              ack1;

  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_wr_count;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_wr_en;

  modport master (
    output req0, valid0, data0, req1, valid1, data1, fifo_full, fifo_wr_count,
    input  gnt0, ack0, gnt1, ack1, fifo_din, fifo_wr_en
  );

  modport slave (
    input  req0, valid0, data0, req1, valid1, data1, fifo_full, fifo_wr_count,
    output gnt0, ack0, gnt1, ack1, fifo_din, fifo_wr_en
  );

endinterface

// File: rtl/fifo_rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// Ports:
//   req[1:0] in  - request vector
//   last     in  - index that won the previous pick
//   any      out - at least one request present
//   winner   out - chosen index (meaningful when any = 1)
module fifo_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       winner
);

  assign any = |req;

  // On a tie the requester that did not win last time goes next; with a
  // single request that requester wins outright.
  always_comb begin
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single write port of the dual-clock test FIFO between two
// requesters in the wr_clk domain. After reset it holds off for RST_WAIT
// cycles (FIFO safety-circuit recovery), then grants fixed-length bursts
// round-robin, only when the FIFO has room for a whole burst.
// Ports:
//   wr_clk      in  write-domain clock
//   fifo_rst_n  in  asynchronous active-low reset
//   bus         slave modport: requester handshakes + FIFO din/wr_en/status
//   init_done   out hold-off window elapsed
//   burst_done  out one-cycle pulse on the last cycle of each burst
//   state_dbg   out current arbiter state
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int RST_WAIT  = DEF_RST_WAIT
) (
  input  logic                 wr_clk,
  input  logic                 fifo_rst_n,
  fifo_wr_arbiter_if.slave     bus,
  output logic                 init_done,
  output logic                 burst_done,
  output state_t               state_dbg
);

  localparam int WAIT_W = $clog2(RST_WAIT + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RST_WAIT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W:0]    DEPTH_V   = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W:0]    BURST_V   = (CNT_W + 1)'(BURST_LEN);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                last_q, last_d;
  logic                sel_q, sel_d;

  logic                any_req;
  logic                winner;
  logic                in_burst;
  logic                req_sel;
  logic                valid_sel;
  logic [DATA_W-1:0]   data_sel;
  logic                accept;
  logic [CNT_W:0]      free_words;
  logic                space_ok;
  logic                done;

  fifo_rr_pick2 u_pick (
    .req    ({bus.req1, bus.req0}),
    .last   (last_q),
    .any    (any_req),
    .winner (winner)
  );

  always_comb begin
    in_burst  = (state_q == BURST);
    req_sel   = sel_q ? bus.req1   : bus.req0;
    valid_sel = sel_q ? bus.valid1 : bus.valid0;
    data_sel  = sel_q ? bus.data1  : bus.data0;
    accept    = in_burst & req_sel & valid_sel & ~bus.fifo_full;
    // One extra bit so DEPTH itself is representable; wr_count never
    // exceeds DEPTH so the subtraction does not wrap.
    free_words = DEPTH_V - {1'b0, bus.fifo_wr_count};
    space_ok   = (free_words >= BURST_V) & ~bus.fifo_full;
  end

  // Next-state and strobe logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    sel_d      = sel_q;
    done       = 1'b0;
    case (state_q)
      WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (any_req && space_ok) begin
          sel_d      = winner;
          last_d     = winner;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (!req_sel) begin
          // Requester gave up the port: end the burst without a write.
          state_d = IDLE;
          done    = 1'b1;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (beat_cnt_q == BEAT_LAST) begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
        // valid low or FIFO full with req held: stall, nothing changes.
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wr_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      state_q    <= WAIT;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
    end
  end

  // Everything visible is decoded from registered state or gated by it,
  // so an asynchronous reset drops grants and write enable immediately.
  assign bus.gnt0       = in_burst & ~sel_q;
  assign bus.gnt1       = in_burst & sel_q;
  assign bus.ack0       = accept & ~sel_q;
  assign bus.ack1       = accept & sel_q;
  assign bus.fifo_wr_en = accept;
  assign bus.fifo_din   = in_burst ? data_sel : '0;
  assign init_done      = (state_q != WAIT);
  assign burst_done     = done;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int DATA_W    = 16;
  localparam int CNT_W     = 9;
  localparam int DEPTH     = 512;
  localparam int BURST_LEN = 16;
  localparam int RST_WAIT  = 80;

  // ---------------- clock / reset ----------------
  logic   wr_clk = 1'b0;
  logic   fifo_rst_n;
  logic   init_done;
  logic   burst_done;
  state_t state_dbg;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  fifo_wr_arbiter #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH),
    .BURST_LEN(BURST_LEN), .RST_WAIT(RST_WAIT)
  ) dut (
    .wr_clk     (wr_clk),
    .fifo_rst_n (fifo_rst_n),
    .bus        (bus.slave),
    .init_done  (init_done),
    .burst_done (burst_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] wr_log[$];
  logic [DATA_W-1:0] exp_q[$];
  bit adv0 = 0;
  bit adv1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // owner: -1 none, else index holding the port. beats: words written in
  // the current burst. held: cycles elapsed since reset release.
  bit m_init  = 0;
  int m_held  = 0;
  int m_owner = -1;
  bit m_last  = 1;
  int m_beats = 0;

  initial begin : cmp
    bit e_g0, e_g1, e_a0, e_a1, e_wr, e_done, e_init, rq, vl;
    logic [DATA_W-1:0] e_din;
    int free, w;
    forever begin
      @(negedge wr_clk);
      e_g0 = 0; e_g1 = 0; e_a0 = 0; e_a1 = 0; e_wr = 0; e_done = 0; e_init = 0;
      e_din = '0;
      if (!fifo_rst_n) begin
        m_init = 0; m_held = 0; m_owner = -1; m_last = 1; m_beats = 0;
      end else begin
        e_init = m_init;
        e_g0 = (m_owner == 0);
        e_g1 = (m_owner == 1);
        if (m_owner >= 0) begin
          rq    = (m_owner == 1) ? bus.req1   : bus.req0;
          vl    = (m_owner == 1) ? bus.valid1 : bus.valid0;
          e_din = (m_owner == 1) ? bus.data1  : bus.data0;
          e_wr  = rq && vl && !bus.fifo_full;
          e_a0  = e_wr && (m_owner == 0);
          e_a1  = e_wr && (m_owner == 1);
          e_done = !rq || (e_wr && (m_beats == BURST_LEN - 1));
        end
      end
      chk("gnt0", bus.gnt0, e_g0);
      chk("gnt1", bus.gnt1, e_g1);
      chk("ack0", bus.ack0, e_a0);
      chk("ack1", bus.ack1, e_a1);
      chk("wr_en", bus.fifo_wr_en, e_wr);
      chk("din", bus.fifo_din, e_din);
      chk("burst_done", burst_done, e_done);
      chk("init_done", init_done, e_init);
      chk("one_grant", bus.gnt0 & bus.gnt1, 0);
      chk("no_wr_when_full", bus.fifo_wr_en & bus.fifo_full, 0);
      adv0 = bus.ack0;
      adv1 = bus.ack1;
      if (bus.fifo_wr_en) wr_log.push_back(bus.fifo_din);
      // advance model to the state after the coming edge
      if (fifo_rst_n) begin
        if (!m_init) begin
          m_held++;
          if (m_held == RST_WAIT) m_init = 1;
        end else if (m_owner < 0) begin
          free = DEPTH - int'(bus.fifo_wr_count);
          if ((bus.req0 || bus.req1) && free >= BURST_LEN && !bus.fifo_full) begin
            if (bus.req0 && bus.req1) w = m_last ? 0 : 1;
            else w = bus.req1 ? 1 : 0;
            m_owner = w; m_last = w[0]; m_beats = 0;
          end
        end else begin
          if (e_done) m_owner = -1;
          else if (e_wr) m_beats++;
        end
      end
    end
  end

  // Requesters step to their next word after each acknowledged write.
  initial begin
    forever begin
      @(posedge wr_clk);
      #1;
      if (adv0) bus.data0 = bus.data0 + 1'b1;
      if (adv1) bus.data1 = bus.data1 + 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic obs();
    @(negedge wr_clk);
    #1;
  endtask

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  // Called in the cycle reset is released, with req0/valid0 high.
  // Measures the hold-off and the first burst, then drops req0.
  task automatic holdoff_burst(output int low, output int first_gnt, output int nwr,
                               output int done_at, output int last_wr_at, output int gnt_after);
    low = 0; first_gnt = -1; nwr = 0; done_at = -1; last_wr_at = -1; gnt_after = -1;
    for (int i = 0; i < 300; i++) begin
      obs();
      if (done_at >= 0) begin
        gnt_after = bus.gnt0;
        break;
      end
      if (!init_done) low++;
      if (bus.gnt0 && first_gnt < 0) first_gnt = i;
      if (bus.fifo_wr_en) begin
        nwr++;
        last_wr_at = i;
      end
      if (burst_done) begin
        done_at = i;
        step();
        bus.req0 = 0;
      end
    end
  endtask

  // Observe until burst_done, counting writes; then release both requests.
  task automatic run_to_done(input int max, inout int nwr, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      obs();
      if (bus.fifo_wr_en) nwr++;
      if (burst_done) begin
        ok = 1;
        step();
        bus.req0 = 0;
        bus.req1 = 0;
        return;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int low, first_gnt, nwr, done_at, last_wr_at, gnt_after, base, gap, cur_w, ndone, w;
    int own[$];
    int bw[$];
    int gaps[$];
    bit ok, prev_any, g, any_g, stall_wr, stall_done, gnt_hold, done_now, wr_now;

    fifo_rst_n = 0;
    bus.req0 = 0; bus.valid0 = 0; bus.data0 = 16'd1;
    bus.req1 = 0; bus.valid1 = 0; bus.data1 = 16'h1001;
    bus.fifo_full = 0; bus.fifo_wr_count = '0;
    repeat (3) step();

    // reset state
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_din", bus.fifo_din, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_burst_done", burst_done, 0);

    // T1/T2: hold-off with req0 held, then one full burst writing 1..16
    bus.req0 = 1; bus.valid0 = 1;
    base = wr_log.size();
    step();
    fifo_rst_n = 1;
    holdoff_burst(low, first_gnt, nwr, done_at, last_wr_at, gnt_after);
    chk("t1_init_low_cycles", low, RST_WAIT);
    chk("t1_first_gnt_cycle", first_gnt, RST_WAIT + 1);
    chk("t2_writes", nwr, BURST_LEN);
    chk("t2_done_with_last_write", done_at, last_wr_at);
    chk("t2_gnt0_after_done", gnt_after, 0);
    for (int k = 0; k < BURST_LEN; k++) exp_q.push_back(DATA_W'(k + 1));
    chk("t2_log_size", wr_log.size() - base, BURST_LEN);
    for (int k = 0; k < BURST_LEN && (base + k) < wr_log.size(); k++) begin
      chk("t2_data", wr_log[base + k], exp_q.pop_front());
    end
    exp_q.delete();

    // T3: both requesting -> alternating bursts (requester 0 won last)
    repeat (2) step();
    bus.req0 = 1; bus.req1 = 1; bus.valid0 = 1; bus.valid1 = 1;
    prev_any = 0; gap = 0; cur_w = 0; ndone = 0;
    for (int i = 0; i < 300; i++) begin
      obs();
      g = bus.gnt0 | bus.gnt1;
      if (g && !prev_any) begin
        own.push_back(bus.gnt1 ? 1 : 0);
        if (own.size() > 1) gaps.push_back(gap);
        gap = 0;
        cur_w = 0;
      end
      if (!g) gap++;
      if (bus.fifo_wr_en) cur_w++;
      if (burst_done) begin
        bw.push_back(cur_w);
        ndone++;
        if (ndone == 4) begin
          step();
          bus.req0 = 0; bus.req1 = 0;
          break;
        end
      end
      prev_any = g;
    end
    chk("t3_bursts", own.size(), 4);
    for (int k = 0; k < own.size(); k++) chk("t3_owner", own[k], (k % 2 == 0) ? 1 : 0);
    for (int k = 0; k < bw.size(); k++) chk("t3_burst_len", bw[k], BURST_LEN);
    chk("t3_gaps", gaps.size(), 3);
    for (int k = 0; k < gaps.size(); k++) chk("t3_gap", gaps[k], 1);

    // T4: 15 free words blocks the grant, 16 free words allows it
    repeat (3) step();
    bus.fifo_wr_count = 9'd497;
    bus.req1 = 1; bus.valid1 = 1;
    any_g = 0;
    repeat (10) begin
      obs();
      any_g |= bus.gnt0 | bus.gnt1;
    end
    chk("t4_no_grant_15_free", any_g, 0);
    step();
    bus.fifo_wr_count = 9'd496;
    obs();
    chk("t4_gnt1_same_cycle", bus.gnt1, 0);
    obs();
    chk("t4_gnt1_next_cycle", bus.gnt1, 1);
    nwr = bus.fifo_wr_en ? 1 : 0;
    run_to_done(60, nwr, ok);
    chk("t4_done_seen", ok, 1);
    chk("t4_writes", nwr, BURST_LEN);
    bus.fifo_wr_count = '0;

    // T5: stalls then early termination after 5 writes
    repeat (2) step();
    bus.req0 = 1; bus.valid0 = 1;
    w = 0;
    for (int i = 0; i < 60 && w < 5; i++) begin
      obs();
      if (bus.fifo_wr_en) w++;
    end
    chk("t5_pre_writes", w, 5);
    step();
    bus.fifo_full = 1;
    stall_wr = 0; stall_done = 0; gnt_hold = 1;
    repeat (3) begin
      obs();
      stall_wr |= bus.fifo_wr_en; stall_done |= burst_done; gnt_hold &= bus.gnt0;
    end
    step();
    bus.fifo_full = 0; bus.valid0 = 0;
    repeat (2) begin
      obs();
      stall_wr |= bus.fifo_wr_en; stall_done |= burst_done; gnt_hold &= bus.gnt0;
    end
    step();
    bus.req0 = 0;
    obs();
    done_now = burst_done; wr_now = bus.fifo_wr_en;
    chk("t5_stall_writes", stall_wr, 0);
    chk("t5_stall_done", stall_done, 0);
    chk("t5_gnt_held", gnt_hold, 1);
    chk("t5_early_done", done_now, 1);
    chk("t5_early_no_write", wr_now, 0);
    obs();
    chk("t5_gnt0_dropped", bus.gnt0, 0);
    step();
    bus.req0 = 1; bus.valid0 = 1;
    nwr = 0;
    run_to_done(60, nwr, ok);
    chk("t5_next_burst_full", nwr, BURST_LEN);

    // T6: reset mid-burst after 7 writes, then full hold-off again
    repeat (2) step();
    bus.req0 = 1; bus.valid0 = 1;
    w = 0;
    for (int i = 0; i < 60 && w < 7; i++) begin
      obs();
      if (bus.fifo_wr_en) w++;
    end
    chk("t6_pre_writes", w, 7);
    @(posedge wr_clk);
    #3;
    fifo_rst_n = 0;
    #1;
    chk("t6_async_wr_en", bus.fifo_wr_en, 0);
    chk("t6_async_gnt0", bus.gnt0, 0);
    chk("t6_async_init", init_done, 0);
    repeat (2) step();
    fifo_rst_n = 1;
    holdoff_burst(low, first_gnt, nwr, done_at, last_wr_at, gnt_after);
    chk("t6_init_low_cycles", low, RST_WAIT);
    chk("t6_first_gnt_cycle", first_gnt, RST_WAIT + 1);
    chk("t6_writes", nwr, BURST_LEN);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
